// File: rtl/ray_pixel_scheduler.sv
// ============================================================================
// Module      : ray_pixel_scheduler
// Description : Raster-scans one frame into the ray generator, one pixel per
//               cycle, throttled by a credit counter; camera latched per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ray_pixel_scheduler #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [95:0]       cam_forward_in,
    input  logic [95:0]       cam_right_in,
    input  logic              credit_return,
    output logic [31:0]       gen_screen_x,
    output logic [31:0]       gen_screen_y,
    output logic              gen_valid,
    output logic              gen_sol,
    output logic              gen_eof,
    output logic [95:0]       cam_forward,
    output logic [95:0]       cam_right,
    output logic [CNT_W-1:0]  inflight,
    output logic              busy,
    output logic              frame_done,
    output logic              credit_err
);

    localparam logic [10:0]      c_X_LAST = 11'(SCREEN_W - 1);
    localparam logic [10:0]      c_Y_LAST = 11'(SCREEN_H - 1);
    localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [10:0]      r_x;
    logic [10:0]      r_y;
    logic [CNT_W-1:0] r_inflight;
    logic [31:0]      r_screen_x;
    logic [31:0]      r_screen_y;
    logic             r_valid;
    logic             r_sol;
    logic             r_eof;
    logic [95:0]      r_cam_forward;
    logic [95:0]      r_cam_right;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_credit_err;

    logic w_issue;
    logic w_ret;
    logic w_last;

    // Issue decisions only see the registered count, so a same-cycle credit
    // cannot enable an issue until the following cycle.
    assign w_issue = (r_state == S_RUN) && (r_inflight < c_MAX);
    assign w_ret   = credit_return && (r_inflight != '0);
    assign w_last  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (frame_start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_RUN;
            S_RUN:   if (w_issue && w_last) w_state_next = S_DRAIN;
            S_DRAIN: if (r_inflight == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_inflight    <= '0;
            r_screen_x    <= '0;
            r_screen_y    <= '0;
            r_valid       <= 1'b0;
            r_sol         <= 1'b0;
            r_eof         <= 1'b0;
            r_cam_forward <= '0;
            r_cam_right   <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_credit_err  <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_cam_forward <= cam_forward_in;
                r_cam_right   <= cam_right_in;
                r_x           <= '0;
                r_y           <= '0;
            end else if (w_issue) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 11'd1;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end

            if (w_issue && !w_ret) begin
                r_inflight <= r_inflight + c_ONE;
            end else if (!w_issue && w_ret) begin
                r_inflight <= r_inflight - c_ONE;
            end

            r_valid      <= w_issue;
            r_screen_x   <= w_issue ? {r_x, 21'b0} : 32'd0;
            r_screen_y   <= w_issue ? {r_y, 21'b0} : 32'd0;
            r_sol        <= w_issue && (r_x == 11'd0);
            r_eof        <= w_issue && w_last;
            r_busy       <= (w_state_next != S_IDLE);
            r_frame_done <= (w_state_next == S_DONE);
            r_credit_err <= r_credit_err | (credit_return && (r_inflight == '0));
        end
    end

    assign gen_screen_x = r_screen_x;
    assign gen_screen_y = r_screen_y;
    assign gen_valid    = r_valid;
    assign gen_sol      = r_sol;
    assign gen_eof      = r_eof;
    assign cam_forward  = r_cam_forward;
    assign cam_right    = r_cam_right;
    assign inflight     = r_inflight;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign credit_err   = r_credit_err;

endmodule

`default_nettype wire

// File: tb/tb_ray_pixel_scheduler.sv
// ============================================================================
// Module      : tb_ray_pixel_scheduler
// Description : Scoreboard bench for ray_pixel_scheduler; two 4x2 instances,
//               one with 16 credits and one with 2 credits.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ray_pixel_scheduler;

    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, fs_a, cret_a, auto_a;
    logic [95:0] camf_in_a, camr_in_a, camf_a, camr_a;
    logic [31:0] gx_a, gy_a;
    logic        gv_a, sol_a, eof_a, busy_a, fd_a, err_a;
    logic [4:0]  inf_a;

    logic        rst_b, fs_b, cret_b, auto_b, man_b;
    logic [95:0] camf_in_b, camr_in_b, camf_b, camr_b;
    logic [31:0] gx_b, gy_b;
    logic        gv_b, sol_b, eof_b, busy_b, fd_b, err_b;
    logic [1:0]  inf_b;

    logic [2:0] pipe_a = '0;
    logic [2:0] pipe_b = '0;

    assign cret_a = auto_a & pipe_a[2];
    assign cret_b = man_b | (auto_b & pipe_b[2]);

    ray_pixel_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .MAX_INFLIGHT(16), .CNT_W(5)) u_dut_a (
        .clk(clk), .rst(rst_a), .frame_start(fs_a),
        .cam_forward_in(camf_in_a), .cam_right_in(camr_in_a), .credit_return(cret_a),
        .gen_screen_x(gx_a), .gen_screen_y(gy_a), .gen_valid(gv_a), .gen_sol(sol_a),
        .gen_eof(eof_a), .cam_forward(camf_a), .cam_right(camr_a), .inflight(inf_a),
        .busy(busy_a), .frame_done(fd_a), .credit_err(err_a)
    );

    ray_pixel_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .MAX_INFLIGHT(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .frame_start(fs_b),
        .cam_forward_in(camf_in_b), .cam_right_in(camr_in_b), .credit_return(cret_b),
        .gen_screen_x(gx_b), .gen_screen_y(gy_b), .gen_valid(gv_b), .gen_sol(sol_b),
        .gen_eof(eof_b), .cam_forward(camf_b), .cam_right(camr_b), .inflight(inf_b),
        .busy(busy_b), .frame_done(fd_b), .credit_err(err_b)
    );

    typedef struct {
        int          d;
        logic [31:0] sx;
        logic [31:0] sy;
        logic        sol;
        logic        eof;
    } pix_t;

    pix_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          gv_cnt[2]   = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          pix_cnt[2]  = '{0, 0};
    logic [95:0] exp_cf[2];
    logic [95:0] exp_cr[2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic gv, input logic [31:0] gx, input logic [31:0] gy,
                       input logic sol, input logic eof, input logic fd, input logic bsy,
                       input logic [95:0] cf, input logic [95:0] cr);
        pix_t p;
        if (!bsy) pix_cnt[d] = 0;
        if (gv) begin
            gv_cnt[d]++;
            pix_cnt[d]++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pixel dut%0d: got x=%0h y=%0h, expected no pixel", d, gx, gy);
            end else begin
                p = exp_q.pop_front();
                chk("pixel_owner", d, p.d);
                chk("screen_x", gx, p.sx);
                chk("screen_y", gy, p.sy);
                chk("sol", sol, p.sol);
                chk("eof", eof, p.eof);
                chk("cam_forward_hold", cf, exp_cf[d]);
                chk("cam_right_hold", cr, exp_cr[d]);
            end
        end else begin
            chk("idle_outputs_zero", {gx, gy, sol, eof}, '0);
        end
        if (fd) begin
            done_cnt[d]++;
            chk("frame_pixel_count", pix_cnt[d], W * H);
            chk("cam_forward_at_done", cf, exp_cf[d]);
            chk("cam_right_at_done", cr, exp_cr[d]);
        end
    endtask

    // Monitor and credit models run exactly on the falling edge; stimulus runs 1ns later.
    always @(negedge clk) begin
        mon(0, gv_a, gx_a, gy_a, sol_a, eof_a, fd_a, busy_a, camf_a, camr_a);
        mon(1, gv_b, gx_b, gy_b, sol_b, eof_b, fd_b, busy_b, camf_b, camr_b);
        pipe_a = {pipe_a[1:0], gv_a};
        pipe_b = {pipe_b[1:0], gv_b};
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int d, input logic [95:0] f, input logic [95:0] r);
        pix_t p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p.d   = d;
                p.sx  = 32'(x) << 21;
                p.sy  = 32'(y) << 21;
                p.sol = (x == 0);
                p.eof = (x == W - 1) && (y == H - 1);
                exp_q.push_back(p);
            end
        end
        exp_cf[d] = f;
        exp_cr[d] = r;
        if (d == 0) begin
            camf_in_a = f; camr_in_a = r; fs_a = 1'b1;
            step();
            fs_a = 1'b0;
        end else begin
            camf_in_b = f; camr_in_b = r; fs_b = 1'b1;
            step();
            fs_b = 1'b0;
        end
    endtask

    task automatic wait_done(input int d, input int base, input int limit);
        int i = 0;
        while (done_cnt[d] == base && i < limit) begin
            step();
            i++;
        end
        chk("frame_done_seen", (done_cnt[d] != base), 1);
    endtask

    initial begin
        int base;
        int g0;
        logic [1:0] exp_inf[6];
        logic       exp_gv[6];
        exp_inf = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        exp_gv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_cf  = '{96'd0, 96'd0};
        exp_cr  = '{96'd0, 96'd0};
        rst_a = 1'b0; fs_a = 1'b0; auto_a = 1'b0; camf_in_a = '0; camr_in_a = '0;
        rst_b = 1'b0; fs_b = 1'b0; auto_b = 1'b0; man_b = 1'b0; camf_in_b = '0; camr_in_b = '0;
        step(3);

        chk("reset_a", {gv_a, inf_a, busy_a, fd_a, err_a, gx_a, gy_a}, '0);
        chk("reset_cam_a", {camf_a, camr_a}, '0);
        chk("reset_b", {gv_b, inf_b, busy_b, fd_b, err_b, gx_b, gy_b}, '0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(2);

        // Full throughput on the 16-credit instance.
        auto_a = 1'b1;
        base = done_cnt[0];
        start_frame(0, {32'h0000_0001, 32'h0020_0000, 32'hFFE0_0000}, {32'h0040_0000, 32'h0, 32'h1});
        chk("busy_in_load", busy_a, 1);
        step();
        chk("latency_no_early_valid", gv_a, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("throughput_valid", gv_a, 1);
            if (i == 3) chk("screen_x_for_x3", gx_a, 32'h0060_0000);
        end
        step();
        chk("valid_after_last", gv_a, 0);
        wait_done(0, base, 40);
        step(2);
        chk("frame_done_once_a", done_cnt[0], base + 1);
        chk("idle_after_frame_a", {busy_a, inf_a}, '0);

        // Camera inputs churn during RUN/DRAIN; a stray frame_start is ignored.
        base = done_cnt[0];
        start_frame(0, {3{32'h1234_5678}}, {3{32'h0BAD_F00D}});
        step(2);
        camf_in_a = {3{32'hDEAD_BEEF}};
        camr_in_a = {3{32'hCAFE_0000}};
        fs_a = 1'b1;
        step();
        fs_a = 1'b0;
        step(6);
        camf_in_a = {3{32'h5555_AAAA}};
        camr_in_a = {3{32'hAAAA_5555}};
        chk("cam_forward_in_drain", camf_a, {3{32'h1234_5678}});
        wait_done(0, base, 40);
        step(20);
        chk("extra_start_ignored", done_cnt[0], base + 1);
        chk("no_restart", busy_a, 0);

        // Credit stall on the 2-credit instance.
        base = done_cnt[1];
        g0 = gv_cnt[1];
        start_frame(1, {3{32'h0000_0111}}, {3{32'h0000_0222}});
        step(10);
        chk("stall_issue_count", gv_cnt[1] - g0, 2);
        chk("stall_inflight", inf_b, 2'd2);
        chk("stall_valid_low", gv_b, 0);
        man_b = 1'b1;
        step();
        man_b = 1'b0;
        step(5);
        chk("one_credit_one_issue", gv_cnt[1] - g0, 3);
        chk("restall_inflight", inf_b, 2'd2);

        // Return held across issue cycles keeps inflight flat with no gaps.
        man_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) man_b = 1'b0;
            chk("simul_inflight", inf_b, exp_inf[i]);
            chk("simul_valid", gv_b, exp_gv[i]);
        end
        chk("simul_issue_count", gv_cnt[1] - g0, 7);

        rst_b = 1'b0;
        #1;
        chk("async_reset_outputs", {gv_b, inf_b, busy_b, fd_b, gx_b, gy_b, sol_b, eof_b}, '0);
        step();
        exp_q.delete();
        rst_b = 1'b1;
        step(4);

        // Reset at the 3rd issue of a fresh frame.
        g0 = gv_cnt[1];
        start_frame(1, {3{32'h0000_0333}}, {3{32'h0000_0444}});
        step(6);
        man_b = 1'b1;
        step();
        man_b = 1'b0;
        for (int i = 0; i < 10 && (gv_cnt[1] - g0) < 3; i++) step();
        chk("third_issue_seen", gv_cnt[1] - g0, 3);
        rst_b = 1'b0;
        #1;
        chk("reset_mid_run", {gv_b, inf_b, busy_b, fd_b, err_b, gx_b, gy_b}, '0);
        chk("reset_mid_run_cam", {camf_b, camr_b}, '0);
        step(2);
        exp_q.delete();
        rst_b = 1'b1;
        step(5);
        chk("no_done_after_abandon", done_cnt[1], base);

        // Full frame after the abandoned one.
        auto_b = 1'b1;
        g0 = gv_cnt[1];
        start_frame(1, {3{32'h0000_0555}}, {3{32'h0000_0666}});
        wait_done(1, base, 200);
        step(3);
        chk("recovered_frame_pixels", gv_cnt[1] - g0, 8);
        chk("recovered_frame_done_once", done_cnt[1], base + 1);

        // Underflow in IDLE sets the sticky error.
        auto_b = 1'b0;
        step(5);
        chk("no_err_before_underflow", err_b, 0);
        man_b = 1'b1;
        step();
        man_b = 1'b0;
        step();
        chk("underflow_inflight", inf_b, 2'd0);
        chk("underflow_err", err_b, 1);

        auto_b = 1'b1;
        base = done_cnt[1];
        start_frame(1, {3{32'h0000_0777}}, {3{32'h0000_0888}});
        wait_done(1, base, 200);
        step(3);
        chk("err_sticky", err_b, 1);
        chk("inflight_zero_after", inf_b, 2'd0);
        chk("no_err_a", err_a, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ray_pixel_scheduler.md
Name: ray_pixel_scheduler

Overview:
- Raster-scans one frame and drives the ray generator's screen_x, screen_y and valid_in inputs, issuing one pixel per cycle.
- Latches the camera basis vectors at frame start and holds them stable for the whole frame, including the pipeline drain.
- Limits in-flight rays with a credit counter, because the ray generator has no back-pressure input.
- Sits between the frame/camera control registers and the ray generator. Downstream returns one credit per ray it consumes.

Parameters:
- SCREEN_W, 640, pixels per line.
- SCREEN_H, 480, lines per frame.
- MAX_INFLIGHT, 16, maximum rays issued but not yet credited back.
- CNT_W, 5, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle request to render one frame
- cam_forward_in  in  96  vec3, Q11.21 per component
- cam_right_in  in  96  vec3, Q11.21 per component
- credit_return  in  1  downstream consumed one ray
- gen_screen_x  out  32  fp Q11.21 pixel column to the ray generator
- gen_screen_y  out  32  fp Q11.21 pixel row to the ray generator
- gen_valid  out  1  valid_in to the ray generator
- gen_sol  out  1  issued pixel has x==0
- gen_eof  out  1  issued pixel is the last pixel of the frame
- cam_forward  out  96  latched camera_forward
- cam_right  out  96  latched camera_right
- inflight  out  CNT_W  current outstanding ray count
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  single-cycle pulse at end of frame
- credit_err  out  1  sticky flag: a credit was returned while inflight==0

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; x/y counters, inflight, all gen_* outputs, cam_* outputs, frame_done and credit_err are 0.
  - Reset mid-frame abandons the frame immediately; no frame_done pulse.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
  - IDLE: frame_start=1 goes to LOAD. frame_start is ignored in every other state.
  - LOAD (1 cycle): cam_forward<=cam_forward_in, cam_right<=cam_right_in; x=y=0; goes to RUN.
  - The cam_* outputs change only in LOAD.
- RUN:
  - Issue condition: inflight < MAX_INFLIGHT.
  - On issue, the next cycle shows gen_valid=1, gen_screen_x={x[10:0],21'b0} zero-extended, and gen_screen_y likewise from y.
  - gen_sol=(x==0); gen_eof=(x==SCREEN_W-1 && y==SCREEN_H-1).
  - Otherwise gen_valid=0, and gen_screen_x/gen_screen_y/gen_sol/gen_eof are 0.
  - Counter advance on issue: x++. At x==SCREEN_W-1, x wraps to 0 and y++.
  - Issuing the last pixel transitions to DRAIN.
- DRAIN: remain until inflight==0 (checked on the registered value), then go to DONE.
- DONE (1 cycle): frame_done=1, then IDLE.
- busy=0 only in IDLE.
- Latency: frame_start sampled at edge t gives LOAD in cycle t+1 and the first gen_valid in cycle t+2, provided credits are available.
- Throughput: one pixel per cycle while credits are available.
- Credit arithmetic:
  - inflight_next = inflight + issue - ret, where ret = credit_return && inflight!=0.
  - Simultaneous issue and return leaves inflight unchanged.
  - A credit returned in cycle n cannot enable an issue decided in cycle n; issue uses the registered inflight.
  - credit_return with inflight==0: ignored (no underflow); credit_err set and held until reset.
- Frame length: exactly SCREEN_W*SCREEN_H gen_valid pulses per frame, in raster order, with no duplicates or skips.

Test Plan:
- Reset mid-RUN (W=4,H=2,MAX=2): assert rst low at the 3rd issue -> all outputs 0 in the same cycle as rst, state IDLE, no frame_done; a subsequent frame_start renders a full 8-pixel frame.
- Full throughput (W=4,H=2,MAX=16; credit_return pulsed 3 cycles after each gen_valid) -> 8 consecutive gen_valid cycles starting t+2 with (x,y)=(0,0)..(3,1); gen_screen_x for x=3 is 32'h00600000; gen_sol on x=0; gen_eof only on (3,1); frame_done exactly once.
- Credit stall (MAX=2, no returns) -> exactly 2 gen_valid pulses, then gen_valid=0 and inflight=2 held; one credit_return -> exactly one more issue.
- Simultaneous issue+return (MAX=2, inflight=1, credit_return high in the issue cycle) -> inflight stays 1 and issuing continues without a gap.
- Camera hold: change cam_forward_in/cam_right_in during RUN and DRAIN, and pulse frame_start during RUN -> cam_forward/cam_right keep their LOAD values; the extra frame_start is ignored and the total pixel count stays W*H.
- Underflow: credit_return with inflight=0 in IDLE -> inflight stays 0; credit_err=1 and remains set through later frames.
